vid_pack: RTL and testbench
===========================

Name: vid_pack

Overview:
- Upstream neighbour of the DRAM write engine, running in the pixel clock domain.
- Takes DE-qualified 16-bit video pixels and packs 8 pixels per 128-bit word.
- Writes 129-bit words (bit 128 = burst-start marker) into the external async write FIFO, always in complete 64-word bursts.
- Publishes the line number and half-line index for each burst, so every burst maps to exactly one 1024-byte DRAM chunk.

Parameters:
- PWIDTH, 16, bits per pixel; fixed, packing assumes 128/PWIDTH = 8 pixels/word.
- H_PIXELS, 1024, max stored pixels per line; pixels beyond this in a line are dropped.
- BURST_WORDS, 64, words per burst; must match the write engine's burst length.
- LINE_BITS, 11, width of the line counter.

Ports:
- pclk  in  1  pixel clock; only clock.
- rstn  in  1  asynchronous active-low reset.
- vsync  in  1  active-high vertical sync.
- de  in  1  active-high data enable.
- pixel  in  16  pixel data, valid when de=1.
- fifo_full  in  1  write FIFO full.
- fifo_din  out  129  {marker, data[127:0]}.
- fifo_wr_en  out  1  FIFO write strobe.
- cline  out  12  {1'b0, line[10:0]} of the current burst.
- cpxl  out  2  {1'b0, half}; half = 0 for pixels 0..511, 1 for 512..1023.
- burst_done  out  1  one-cycle pulse after the 64th word of a burst is issued.
- ovf  out  1  sticky; a word or pixel was lost.

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0; state IDLE; counters, shift register and vsync-edge register cleared.
- Packing: pixel k of a word goes to data[16k+15:16k] (first pixel in bits [15:0]).
- Word issue: the word is registered and written on the cycle after the 8th pixel is accepted (latency 1). fifo_din is valid whenever fifo_wr_en=1.
- Word counter: wcnt 0..63 within a burst. Marker = 1 iff wcnt==0.
  - cline/cpxl update on the cycle their burst's word 0 is issued.
  - They hold until the next word 0.
- Burst mapping: line pixels 0..511 form burst half 0; pixels 512..1023 form burst half 1.
- State machine:
  - IDLE: de rise -> PACK. If a vsync rise is pending, line counter = 0 and pending is cleared.
  - PACK: accept pixels while de=1 and hcnt < H_PIXELS. Excess pixels are ignored without setting ovf. de fall -> PAD.
  - PAD: if the shift register is partial, issue it zero-filled. Then issue zero words until wcnt wraps to 0 (burst complete), then -> IDLE. Line counter increments by 1 on exit (wraps at 2^LINE_BITS). PAD issues one word per cycle.
  - A line ending exactly on a burst boundary with an empty shift register goes PAD -> IDLE in one cycle with no padding.
  - A zero-length line (de high with no pixels accepted, i.e. hcnt=0 at de fall) issues no words but still increments the line counter.
- vsync: a rising edge (registered) sets vs_pend. A line in progress completes normally, and the reset is applied at the next de rise.
- Boundary conditions:
  - Overflow: fifo_full=1 when a word is due -> the word is discarded (fifo_wr_en stays 0), ovf is set, and wcnt still advances so burst alignment is kept.
  - de during PAD (blanking too short): those pixels are dropped and ovf is set. The dropped line is still counted once de falls.
  - ovf is cleared only by reset.
- burst_done: asserted the cycle after the word with wcnt==63 is issued. It is also asserted if that word was discarded for overflow.

Test Plan:
- One 1024-pixel line, pixel value = index, fifo_full=0 -> 128 writes.
  - Word 0: marker=1, data[15:0]=0, data[127:112]=7.
  - Word 64: marker=1, cpxl=1.
  - burst_done pulses twice.
  - cline=0.
- Line of 100 pixels -> exactly 64 writes.
  - Word 12: pixels 96..99 in bits [63:0], bits [127:64]=0.
  - Words 13..63 all zero.
  - One burst_done.
- Three lines after a vsync rise, then a vsync rise, then one line -> bursts carry cline 0, 1, 2, then 0 again.
- fifo_full forced high for words 10..12 of a 1024-pixel line:
  - 125 writes total, ovf=1.
  - Word 64 still has marker=1 and cpxl=1.
- de reasserted 5 cycles after falling on a 600-pixel line:
  - Those pixels dropped, ovf=1.
  - First line padded to 128 total words; the next line is counted.
- rstn pulled low mid-burst (word 30):
  - All outputs 0 immediately.
  - After release, the next line starts at wcnt=0 with marker=1, cline=0.

Source files
------------

// File: rtl/vid_pack.sv
// vid_pack: packs DE-qualified video pixels into 128-bit words and hands them
// to the external async write FIFO as complete bursts of BURST_WORDS words.
// Each burst covers one half of a stored line, so it maps to exactly one
// 1024-byte DRAM chunk. The line number and half index of the burst being
// written are published alongside the data.
//
// Ports:
//   pclk        pixel clock (only clock)
//   rstn        asynchronous active-low reset
//   vsync       active-high vertical sync; a rising edge restarts line numbering
//               at the next line start
//   de          active-high data enable
//   pixel       pixel data, valid when de=1
//   fifo_full   write FIFO full; a word due while full is discarded
//   fifo_din    {burst-start marker, data[127:0]}, valid when fifo_wr_en=1
//   fifo_wr_en  FIFO write strobe
//   cline       {1'b0, line} of the current burst
//   cpxl        {1'b0, half}; half selects pixels 0..511 or 512..1023
//   burst_done  one-cycle pulse the cycle after the last word of a burst
//   ovf         sticky: a word or pixel was lost; cleared only by reset
module vid_pack #(
    parameter int PWIDTH      = 16,
    parameter int H_PIXELS    = 1024,
    parameter int BURST_WORDS = 64,
    parameter int LINE_BITS   = 11
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              vsync,
    input  logic              de,
    input  logic [PWIDTH-1:0] pixel,
    input  logic              fifo_full,
    output logic [128:0]      fifo_din,
    output logic              fifo_wr_en,
    output logic [11:0]       cline,
    output logic [1:0]        cpxl,
    output logic              burst_done,
    output logic              ovf
);

    localparam int PIX_PER_WORD = 128 / PWIDTH;
    localparam int HCNT_W       = $clog2(H_PIXELS + 1);
    localparam int WCNT_W       = $clog2(BURST_WORDS);
    localparam int PCNT_W       = $clog2(PIX_PER_WORD);

    localparam logic [HCNT_W-1:0] HPIX_MAX  = HCNT_W'(H_PIXELS);
    localparam logic [HCNT_W-1:0] HALF_PIX  = HCNT_W'(H_PIXELS / 2);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PIX_PER_WORD - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BURST_WORDS - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [LINE_BITS-1:0] LINE_ONE = LINE_BITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        PAD  = 2'd2
    } state_t;

    // Places one pixel into its slot; slot k occupies bits [16k+15:16k].
    function automatic logic [127:0] slot_insert(
        input logic [127:0]      word,
        input logic [PCNT_W-1:0] slot,
        input logic [PWIDTH-1:0] pix
    );
        logic [127:0] res;
        res = word;
        res[slot*PWIDTH +: PWIDTH] = pix;
        return res;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  vs_d_r;
    logic                  de_d_r;
    logic                  vs_pend_r;
    logic                  drop_pend_r;
    logic [LINE_BITS-1:0]  line_r;
    logic [HCNT_W-1:0]     hcnt_r;
    logic [PCNT_W-1:0]     pcnt_r;
    logic [WCNT_W-1:0]     wcnt_r;
    logic [127:0]          shift_r;
    logic                  last_r;

    logic [128:0]          fifo_din_r;
    logic                  fifo_wr_en_r;
    logic [11:0]           cline_r;
    logic [1:0]            cpxl_r;
    logic                  burst_done_r;
    logic                  ovf_r;

    logic                  de_rise_s;
    logic                  vs_rise_s;
    logic                  accept_s;
    logic                  issue_s;
    logic                  line_start_s;
    logic                  line_end_s;
    logic                  drop_pix_s;
    logic                  drop_line_s;
    logic                  half_s;
    logic [127:0]          word_s;
    logic [HCNT_W-1:0]     last_idx_s;

    assign de_rise_s  = de & ~de_d_r;
    assign vs_rise_s  = vsync & ~vs_d_r;
    // Index of the most recently stored pixel; only used in PAD, where hcnt_r >= 1
    // whenever a partial word is still waiting.
    assign last_idx_s = hcnt_r - HCNT_ONE;

    // State register.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        line_start_s = 1'b0;
        line_end_s   = 1'b0;
        drop_pix_s   = 1'b0;
        drop_line_s  = 1'b0;
        half_s       = 1'b0;
        word_s       = shift_r;
        case (state_r)
            IDLE: begin
                if (de_rise_s) begin
                    // The pixel on the rising-edge cycle is pixel 0 of the line.
                    accept_s     = 1'b1;
                    line_start_s = 1'b1;
                    word_s       = slot_insert(shift_r, pcnt_r, pixel);
                    state_nxt_s  = PACK;
                end else if (drop_pend_r && !de) begin
                    // A line that arrived during padding is counted once it ends.
                    drop_line_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PACK: begin
                if (de) begin
                    state_nxt_s = PACK;
                    if (hcnt_r < HPIX_MAX) begin
                        accept_s = 1'b1;
                        word_s   = slot_insert(shift_r, pcnt_r, pixel);
                        half_s   = (hcnt_r >= HALF_PIX);
                        issue_s  = (pcnt_r == PCNT_LAST);
                    end else begin
                        // Pixels past the stored line width are silently ignored.
                        accept_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = PAD;
                end
            end
            PAD: begin
                drop_pix_s = de;
                half_s     = (last_idx_s >= HALF_PIX);
                if ((pcnt_r == {PCNT_W{1'b0}}) && (wcnt_r == {WCNT_W{1'b0}})) begin
                    // Burst already complete (or nothing stored): leave without padding.
                    line_end_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    // shift_r is zero beyond the stored pixels, so one path covers
                    // both the partial word and the pure zero-fill words.
                    issue_s = 1'b1;
                    if (wcnt_r == WCNT_LAST) begin
                        line_end_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = PAD;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Edge-detect history for vsync and de.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            vs_d_r <= 1'b0;
            de_d_r <= 1'b0;
        end else begin
            vs_d_r <= vsync;
            de_d_r <= de;
        end
    end

    // Pending vsync and pending dropped-line flags.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            vs_pend_r   <= 1'b0;
            drop_pend_r <= 1'b0;
        end else begin
            vs_pend_r   <= vs_rise_s | (vs_pend_r & ~line_start_s);
            drop_pend_r <= drop_pix_s | (drop_pend_r & ~drop_line_s);
        end
    end

    // Line counter: restarts at a line start after vsync, advances per finished line.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            line_r <= {LINE_BITS{1'b0}};
        end else if (line_start_s && vs_pend_r) begin
            line_r <= {LINE_BITS{1'b0}};
        end else if (line_end_s || drop_line_s) begin
            line_r <= line_r + LINE_ONE;
        end else begin
            line_r <= line_r;
        end
    end

    // Pixel counters and the word assembly register.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            hcnt_r  <= {HCNT_W{1'b0}};
            pcnt_r  <= {PCNT_W{1'b0}};
            shift_r <= 128'd0;
        end else begin
            if (line_start_s) begin
                hcnt_r <= HCNT_ONE;
            end else if (accept_s) begin
                hcnt_r <= hcnt_r + HCNT_ONE;
            end else if (line_end_s) begin
                hcnt_r <= {HCNT_W{1'b0}};
            end else begin
                hcnt_r <= hcnt_r;
            end
            // Clearing on issue keeps unused slots zero for the padded word.
            if (issue_s) begin
                pcnt_r  <= {PCNT_W{1'b0}};
                shift_r <= 128'd0;
            end else if (accept_s) begin
                pcnt_r  <= pcnt_r + PCNT_ONE;
                shift_r <= word_s;
            end else begin
                pcnt_r  <= pcnt_r;
                shift_r <= shift_r;
            end
        end
    end

    // Word counter advances on every issued word, written or discarded,
    // so burst alignment survives a full FIFO.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            wcnt_r <= {WCNT_W{1'b0}};
        end else if (issue_s) begin
            wcnt_r <= wcnt_r + WCNT_ONE;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // FIFO write port, burst tag outputs, burst completion and overflow flag.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            fifo_din_r   <= 129'd0;
            fifo_wr_en_r <= 1'b0;
            cline_r      <= 12'd0;
            cpxl_r       <= 2'd0;
            last_r       <= 1'b0;
            burst_done_r <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            fifo_wr_en_r <= issue_s & ~fifo_full;
            if (issue_s && !fifo_full) begin
                fifo_din_r <= {(wcnt_r == {WCNT_W{1'b0}}), word_s};
            end else begin
                fifo_din_r <= fifo_din_r;
            end
            if (issue_s && (wcnt_r == {WCNT_W{1'b0}})) begin
                cline_r <= {{(12-LINE_BITS){1'b0}}, line_r};
                cpxl_r  <= {1'b0, half_s};
            end else begin
                cline_r <= cline_r;
                cpxl_r  <= cpxl_r;
            end
            last_r       <= issue_s & (wcnt_r == WCNT_LAST);
            burst_done_r <= last_r;
            ovf_r        <= ovf_r | (issue_s & fifo_full) | drop_pix_s;
        end
    end

    assign fifo_din   = fifo_din_r;
    assign fifo_wr_en = fifo_wr_en_r;
    assign cline      = cline_r;
    assign cpxl       = cpxl_r;
    assign burst_done = burst_done_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_vid_pack.sv
// Scoreboard bench for vid_pack: a line-level reference model pushes the
// expected FIFO words; an independent monitor pops and compares on each write.
module tb_vid_pack;

    logic         pclk;
    logic         rstn;
    logic         vsync;
    logic         de;
    logic [15:0]  pixel;
    logic         fifo_full;
    logic [128:0] fifo_din;
    logic         fifo_wr_en;
    logic [11:0]  cline;
    logic [1:0]   cpxl;
    logic         burst_done;
    logic         ovf;

    vid_pack dut (
        .pclk       (pclk),
        .rstn       (rstn),
        .vsync      (vsync),
        .de         (de),
        .pixel      (pixel),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .cline      (cline),
        .cpxl       (cpxl),
        .burst_done (burst_done),
        .ovf        (ovf)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [128:0] din;
        logic [11:0]  cl;
        logic [1:0]   cp;
        logic         last;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] marker_cl[$];
    logic [15:0] pix [0:1099];
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          bd_cnt = 0;
    int          m_line = 0;
    bit          m_vs   = 1'b0;

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one line of n pixels; words dlo..dhi are lost to a full FIFO.
    task automatic model_line(input int n, input int dlo, input int dhi);
        int   acc;
        int   nw;
        exp_t e;
        if (m_vs) begin
            m_line = 0;
            m_vs   = 1'b0;
        end
        acc = (n > 1024) ? 1024 : n;
        nw  = (acc + 7) / 8;
        nw  = ((nw + 63) / 64) * 64;
        for (int j = 0; j < nw; j++) begin
            e.din = '0;
            for (int k = 0; k < 8; k++)
                if (8*j + k < acc) e.din[16*k +: 16] = pix[8*j + k];
            e.din[128] = (j % 64 == 0);
            e.cl   = 12'(m_line);
            e.cp   = 2'(j / 64);
            e.last = (j % 64 == 63);
            if (j < dlo || j > dhi) exp_q.push_back(e);
        end
        m_line = (m_line + 1) % 2048;
    endtask

    task automatic drive_line(input int n, input int flo, input int fhi, input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            de        = 1'b1;
            pixel     = pix[i];
            fifo_full = ((i / 8) >= flo) && ((i / 8) <= fhi);
        end
        @(posedge pclk); #1;
        de        = 1'b0;
        pixel     = 16'd0;
        fifo_full = 1'b0;
        repeat (gap) @(posedge pclk);
    endtask

    task automatic vsync_pulse();
        @(posedge pclk); #1;
        vsync = 1'b1;
        repeat (2) @(posedge pclk);
        #1 vsync = 1'b0;
        m_vs = 1'b1;
        repeat (2) @(posedge pclk);
    endtask

    task automatic rand_pix();
        for (int i = 0; i < 1100; i++) pix[i] = 16'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, {128'd0, fifo_wr_en}, 129'd0);
        chk({tag, "_din"}, fifo_din, 129'd0);
        chk({tag, "_cline"}, {117'd0, cline}, 129'd0);
        chk({tag, "_cpxl"}, {127'd0, cpxl}, 129'd0);
        chk({tag, "_bdone"}, {128'd0, burst_done}, 129'd0);
        chk({tag, "_ovf"}, {128'd0, ovf}, 129'd0);
    endtask

    // Monitor: compares every FIFO write and every burst_done pulse.
    bit   bd_exp = 1'b0;
    exp_t cur;
    always @(negedge pclk) begin
        if (!rstn) begin
            bd_exp = 1'b0;
        end else begin
            if (burst_done || bd_exp) chk("burst_done", {128'd0, burst_done}, {128'd0, bd_exp});
            if (burst_done) bd_cnt++;
            bd_exp = 1'b0;
            if (fifo_wr_en) begin
                wr_cnt++;
                if (fifo_din[128]) marker_cl.push_back(cline);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {128'd0, fifo_wr_en}, 129'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("fifo_din", fifo_din, cur.din);
                    chk("cline", {117'd0, cline}, {117'd0, cur.cl});
                    chk("cpxl", {127'd0, cpxl}, {127'd0, cur.cp});
                    bd_exp = cur.last;
                end
            end
        end
    end

    int w0;
    int b0;

    initial begin
        rstn = 1'b0; vsync = 1'b0; de = 1'b0; pixel = 16'd0; fifo_full = 1'b0;
        repeat (3) @(posedge pclk);
        #1 chk_zero("reset");
        rstn = 1'b1;
        repeat (2) @(posedge pclk);

        // Full line, pixel value = index.
        for (int i = 0; i < 1100; i++) pix[i] = 16'(i);
        w0 = wr_cnt; b0 = bd_cnt;
        model_line(1024, -1, -1);
        drive_line(1024, -1, -1, 80);
        chk("t1_writes", 129'(wr_cnt - w0), 129'd128);
        chk("t1_bdone", 129'(bd_cnt - b0), 129'd2);
        chk("t1_ovf", {128'd0, ovf}, 129'd0);

        // Short line padded to one burst.
        rand_pix();
        w0 = wr_cnt; b0 = bd_cnt;
        model_line(100, -1, -1);
        drive_line(100, -1, -1, 80);
        chk("t2_writes", 129'(wr_cnt - w0), 129'd64);
        chk("t2_bdone", 129'(bd_cnt - b0), 129'd1);

        // vsync restarts line numbering at the next line.
        marker_cl.delete();
        vsync_pulse();
        rand_pix(); model_line(8, -1, -1);   drive_line(8, -1, -1, 80);
        rand_pix(); model_line(200, -1, -1); drive_line(200, -1, -1, 80);
        rand_pix(); model_line(520, -1, -1); drive_line(520, -1, -1, 80);
        vsync_pulse();
        rand_pix(); model_line(64, -1, -1);  drive_line(64, -1, -1, 80);
        chk("t3_bursts", 129'(marker_cl.size()), 129'd5);
        if (marker_cl.size() == 5) begin
            chk("t3_cl0", {117'd0, marker_cl[0]}, 129'd0);
            chk("t3_cl1", {117'd0, marker_cl[1]}, 129'd1);
            chk("t3_cl2", {117'd0, marker_cl[2]}, 129'd2);
            chk("t3_cl3", {117'd0, marker_cl[3]}, 129'd2);
            chk("t3_cl4", {117'd0, marker_cl[4]}, 129'd0);
        end

        // FIFO full while words 10..12 are due.
        rand_pix();
        w0 = wr_cnt; b0 = bd_cnt;
        model_line(1024, 10, 12);
        drive_line(1024, 10, 12, 80);
        chk("t4_writes", 129'(wr_cnt - w0), 129'd125);
        chk("t4_bdone", 129'(bd_cnt - b0), 129'd2);
        chk("t4_ovf", {128'd0, ovf}, 129'd1);

        // Reset asserted around word 30 of a line.
        rand_pix();
        model_line(1024, -1, -1);
        for (int i = 0; i < 250; i++) begin
            @(posedge pclk); #1;
            de = 1'b1; pixel = pix[i];
        end
        @(posedge pclk); #2;
        rstn = 1'b0;
        #1 chk_zero("midrst");
        de = 1'b0; pixel = 16'd0;
        exp_q.delete();
        m_line = 0; m_vs = 1'b0;
        repeat (3) @(posedge pclk);
        #2 rstn = 1'b1;
        repeat (5) @(posedge pclk);

        // Over-long line after reset: excess pixels dropped without ovf.
        rand_pix();
        marker_cl.delete();
        w0 = wr_cnt;
        model_line(1100, -1, -1);
        drive_line(1100, -1, -1, 80);
        chk("t6_writes", 129'(wr_cnt - w0), 129'd128);
        chk("t6_ovf", {128'd0, ovf}, 129'd0);
        if (marker_cl.size() > 0) chk("t6_first_cline", {117'd0, marker_cl[0]}, 129'd0);
        else chk("t6_markers", 129'(marker_cl.size()), 129'd2);

        // de reasserted during padding: pixels dropped, line still counted.
        rand_pix();
        w0 = wr_cnt;
        model_line(600, -1, -1);
        m_line = (m_line + 1) % 2048;
        drive_line(600, -1, -1, 5);
        for (int i = 0; i < 20; i++) begin
            @(posedge pclk); #1;
            de = 1'b1; pixel = 16'($urandom);
        end
        @(posedge pclk); #1;
        de = 1'b0; pixel = 16'd0;
        repeat (80) @(posedge pclk);
        rand_pix();
        model_line(64, -1, -1);
        drive_line(64, -1, -1, 80);
        chk("t5_writes", 129'(wr_cnt - w0), 129'd192);
        chk("t5_ovf", {128'd0, ovf}, 129'd1);

        chk("queue_empty", 129'(exp_q.size()), 129'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
